d_ff_en: RTL and testbench



---
 rtl/d_ff_en.sv | 28 ++
 tb/tb_d_ff_en.sv | 127 ++++++++++++
 2 files changed

// File: rtl/d_ff_en.sv
// W-bit D register with synchronous load-enable and asynchronous active-high reset.
// Q comes straight from the storage flop, so D and enable have no combinational path to it.
`timescale 1ns/1ps
module d_ff_en #(
  parameter int           W       = 5,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] r_q;

  // The parent deasserts rst away from the clk edge, so no release synchroniser is needed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (enable) begin
      r_q <= D;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_d_ff_en.sv
// Directed bench for d_ff_en: a default W=5 instance driven from a vector table,
// plus a W=8 / RST_VAL=8'hA5 instance and a few hand-written corner sequences.
`timescale 1ns/1ps
module tb_d_ff_en;

  logic       clk = 1'b0;
  logic       rst_a, en_a;
  logic [4:0] d_a, q_a;
  logic       rst_b, en_b;
  logic [7:0] d_b, q_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;  // rising edges at 5, 15, 25, ... ns

  d_ff_en dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .enable (en_a),
    .D      (d_a),
    .Q      (q_a)
  );

  d_ff_en #(.W(8), .RST_VAL(8'hA5)) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .enable (en_b),
    .D      (d_b),
    .Q      (q_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [4:0] d;
    logic [4:0] exp_q;  // Q after the edge 5 ns later
  } vec_t;

  vec_t vecs [12];

  task automatic at_time(input longint t);
    if ($time < t) #(t - $time);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end else begin
      $display("ok   %s at %0t: Q=%h", name, $time, act);
    end
  endtask

  initial begin
    logic [4:0] prev_q;

    rst_a = 1'b0; en_a = 1'b0; d_a = 5'b00000;
    rst_b = 1'b0; en_b = 1'b0; d_b = 8'h00;

    // Each row is driven at 100 + 10*i ns, between edges.
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 5'b00000};
    vecs[1]  = '{1'b0, 1'b1, 5'b00000, 5'b00000};
    vecs[2]  = '{1'b0, 1'b1, 5'b11001, 5'b11001};
    vecs[3]  = '{1'b0, 1'b0, 5'b11001, 5'b11001};
    vecs[4]  = '{1'b0, 1'b0, 5'b11111, 5'b11001};
    vecs[5]  = '{1'b0, 1'b0, 5'b11111, 5'b11001};
    vecs[6]  = '{1'b0, 1'b0, 5'b11111, 5'b11001};
    vecs[7]  = '{1'b0, 1'b1, 5'b11111, 5'b11111};
    vecs[8]  = '{1'b0, 1'b1, 5'b11111, 5'b11111};
    vecs[9]  = '{1'b1, 1'b1, 5'b11111, 5'b00000};
    vecs[10] = '{1'b1, 1'b1, 5'b11111, 5'b00000};
    vecs[11] = '{1'b1, 1'b1, 5'b11111, 5'b00000};

    prev_q = 5'b00000;
    for (int i = 0; i < 12; i++) begin
      at_time(100 + 10 * i);
      rst_a = vecs[i].rst;
      en_a  = vecs[i].en;
      d_a   = vecs[i].d;
      // 1 ns after the drive: reset acts at once, otherwise Q must not have moved.
      #1;
      if (vecs[i].rst) check($sformatf("vec%0d_async", i), {3'b0, q_a}, 8'h00);
      else if (i > 0)  check($sformatf("vec%0d_between", i), {3'b0, q_a}, {3'b0, prev_q});
      // 1 ns after the following rising edge.
      #5;
      check($sformatf("vec%0d_edge", i), {3'b0, q_a}, {3'b0, vecs[i].exp_q});
      prev_q = vecs[i].exp_q;
    end

    // Release reset, then pulse enable between edges only: the next edge must not load.
    at_time(222); rst_a = 1'b0; en_a = 1'b0; d_a = 5'b10101;
    at_time(227); en_a = 1'b1;
    at_time(230); en_a = 1'b0;
    at_time(236); check("en_pulse_between_edges", {3'b0, q_a}, 8'h00);

    // First enabled edge after release loads D.
    at_time(240); en_a = 1'b1; d_a = 5'b01010;
    at_time(241); check("no_comb_path", {3'b0, q_a}, 8'h00);
    at_time(246); check("load_after_release", {3'b0, q_a}, 8'h0A);

    // A falling edge (250 ns) with enable high and new D must not load.
    at_time(247); d_a = 5'b00111;
    at_time(251); check("falling_edge_ignored", {3'b0, q_a}, 8'h0A);
    at_time(256); check("rising_edge_loads", {3'b0, q_a}, 8'h07);

    // W=8, RST_VAL=A5 instance.
    at_time(300); rst_b = 1'b1; en_b = 1'b1; d_b = 8'h3C;
    at_time(301); check("w8_reset_async", q_b, 8'hA5);
    at_time(306); check("w8_reset_beats_enable", q_b, 8'hA5);
    at_time(310); rst_b = 1'b0;
    at_time(311); check("w8_release_holds", q_b, 8'hA5);
    at_time(316); check("w8_load", q_b, 8'h3C);
    at_time(320); en_b = 1'b0; d_b = 8'hFF;
    at_time(326); check("w8_hold", q_b, 8'h3C);
    at_time(330); en_b = 1'b1;
    at_time(336); check("w8_all_bits_load", q_b, 8'hFF);
    at_time(340); rst_b = 1'b1;
    at_time(341); check("w8_mid_reset", q_b, 8'hA5);

    at_time(360);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
